music_sequencer: RTL and testbench

//  Sequences the dual-note music ROM: steps the 10-bit beat address at a fixed tempo, fetches

---
 rtl/music_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_music_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// music_sequencer
//   Steps through the dual-note music ROM at a fixed tempo. Each beat the
//   current address is presented to the ROM and the returned {note1,note2}
//   word is captured. The word is then held on the note outputs for the
//   beat, followed by a short silent gap. Supports play/pause (level), stop
//   (pulse, rewind to 0), end-of-tune detection on note1 == END_NOTE, and
//   optional looping back to address 0.
//
//   Parameter constraints: BEAT_CYCLES >= 4, GAP_CYCLES < BEAT_CYCLES-2.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   play         in   level: 1 = run, 0 = pause
//   stop         in   one-cycle pulse: abort and rewind to address 0
//   loop_en      in   1 = restart at address 0 on END_NOTE, 0 = halt
//   rom_addr     out  registered ROM address (ROM addr_in)
//   rom_note1    in   ROM note1, valid one cycle after rom_addr is sampled
//   rom_note2    in   ROM note2
//   note1_out    out  current note 1 to tone generator (0 = rest)
//   note2_out    out  current note 2 to tone generator (0 = rest)
//   beat_strobe  out  one-cycle pulse when new notes are loaded
//   playing      out  high while fetching, capturing or sounding
//   done         out  one-cycle pulse when the tune ends with loop_en = 0
module music_sequencer #(
  parameter int         ADDR_W      = 10,
  parameter int         MAX_ADDR    = 511,
  parameter int         BEAT_CYCLES = 12_500_000,
  parameter int         GAP_CYCLES  = 1_250_000,
  parameter logic [6:0] END_NOTE    = 7'h7F
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [6:0]        rom_note1,
  input  logic [6:0]        rom_note2,
  output logic [6:0]        note1_out,
  output logic [6:0]        note2_out,
  output logic              beat_strobe,
  output logic              playing,
  output logic              done
);

  localparam int                CNT_W     = $clog2(BEAT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_START = CNT_W'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SOUND,
    S_PAUSE
  } state_t;

  state_t            state_reg,        state_next;
  logic [ADDR_W-1:0] addr_reg,         addr_next;
  logic [CNT_W-1:0]  cnt_reg,          cnt_next;
  logic [6:0]        note1_reg,        note1_next;
  logic [6:0]        note2_reg,        note2_next;
  logic              strobe_reg,       strobe_next;
  logic              done_reg,         done_next;
  // Remembers whether the pause interrupted the sounding part of the beat;
  // a pause in FETCH/CAPTURE restarts the fetch so the ROM is re-read.
  logic              resume_sound_reg, resume_sound_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg        <= S_IDLE;
      addr_reg         <= '0;
      cnt_reg          <= '0;
      note1_reg        <= '0;
      note2_reg        <= '0;
      strobe_reg       <= 1'b0;
      done_reg         <= 1'b0;
      resume_sound_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      cnt_reg          <= cnt_next;
      note1_reg        <= note1_next;
      note2_reg        <= note2_next;
      strobe_reg       <= strobe_next;
      done_reg         <= done_next;
      resume_sound_reg <= resume_sound_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    cnt_next          = cnt_reg;
    note1_next        = note1_reg;
    note2_next        = note2_reg;
    strobe_next       = 1'b0;
    done_next         = 1'b0;
    resume_sound_next = resume_sound_reg;

    if (stop) begin
      // Stop beats everything, including a simultaneous play.
      state_next = S_IDLE;
      addr_next  = '0;
      cnt_next   = '0;
      note1_next = '0;
      note2_next = '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (play) begin
            state_next = S_FETCH;
            cnt_next   = '0;
          end
        end

        S_FETCH: begin
          if (!play) begin
            state_next        = S_PAUSE;
            resume_sound_next = 1'b0;
          end else begin
            state_next = S_CAPTURE;
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          if (!play) begin
            state_next        = S_PAUSE;
            resume_sound_next = 1'b0;
          end else if (rom_note1 == END_NOTE) begin
            // End marker is never sounded; rewind and either loop or halt.
            addr_next  = '0;
            cnt_next   = '0;
            note1_next = '0;
            note2_next = '0;
            if (loop_en) begin
              state_next = S_FETCH;
            end else begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            note1_next  = rom_note1;
            note2_next  = rom_note2;
            strobe_next = 1'b1;
            state_next  = S_SOUND;
            cnt_next    = cnt_reg + CNT_W'(1);
          end
        end

        S_SOUND: begin
          if (!play) begin
            state_next        = S_PAUSE;
            resume_sound_next = 1'b1;
          end else if (cnt_reg == LAST_CNT) begin
            addr_next  = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
            cnt_next   = '0;
            state_next = S_FETCH;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        S_PAUSE: begin
          if (play) begin
            if (resume_sound_reg) begin
              state_next = S_SOUND;
            end else begin
              state_next = S_FETCH;
              cnt_next   = '0;
            end
          end
        end

        default: begin
          state_next = S_IDLE;
          addr_next  = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // SOUND is only entered at count 2, so only the gap boundary needs testing.
  logic sounding;
  assign sounding    = (state_reg == S_SOUND) && (cnt_reg < GAP_START);

  assign note1_out   = sounding ? note1_reg : 7'd0;
  assign note2_out   = sounding ? note2_reg : 7'd0;
  assign rom_addr    = addr_reg;
  assign beat_strobe = strobe_reg;
  assign done        = done_reg;
  assign playing     = (state_reg == S_FETCH) || (state_reg == S_CAPTURE) ||
                       (state_reg == S_SOUND);

endmodule

// File: tb/tb_music_sequencer.sv
// Testbench for music_sequencer: directed scenarios followed by a randomized
// run, every cycle checked against a beat-position reference model.
module tb_music_sequencer;

  localparam int         ADDR_W   = 10;
  localparam int         MAX_ADDR = 7;
  localparam int         BEAT     = 8;
  localparam int         GAP      = 2;
  localparam logic [6:0] END_NOTE = 7'h7F;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [6:0]        rom_note1, rom_note2;
  logic [6:0]        note1_out, note2_out;
  logic              beat_strobe, playing, done;

  logic [6:0] rom1 [0:1023];
  logic [6:0] rom2 [0:1023];

  int total = 0;
  int bad   = 0;

  // Reference model: run mode, position within the beat, address, held word.
  int         m_mode;
  int         m_pos;
  int         m_addr;
  logic [6:0] m_n1, m_n2;
  logic       m_strobe, m_done;

  music_sequencer #(
    .ADDR_W      (ADDR_W),
    .MAX_ADDR    (MAX_ADDR),
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .END_NOTE    (END_NOTE)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .play        (play),
    .stop        (stop),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_note1   (rom_note1),
    .rom_note2   (rom_note2),
    .note1_out   (note1_out),
    .note2_out   (note2_out),
    .beat_strobe (beat_strobe),
    .playing     (playing),
    .done        (done)
  );

  always #5 sys_clk = ~sys_clk;

  // Music ROM with one cycle of read latency.
  always_ff @(posedge sys_clk) begin
    rom_note1 <= rom1[rom_addr];
    rom_note2 <= rom2[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_pos    = 0;
    m_addr   = 0;
    m_n1     = '0;
    m_n2     = '0;
    m_strobe = 1'b0;
    m_done   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs as they will be sampled.
  task automatic model_step();
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (!sys_rst_n) begin
      model_reset();
    end else if (stop) begin
      m_mode = M_IDLE; m_addr = 0; m_pos = 0; m_n1 = '0; m_n2 = '0;
    end else if (m_mode == M_IDLE) begin
      if (play) begin m_mode = M_RUN; m_pos = 0; end
    end else if (m_mode == M_PAUSE) begin
      if (play) begin
        m_mode = M_RUN;
        if (m_pos < 2) m_pos = 0;
      end
    end else if (!play) begin
      m_mode = M_PAUSE;
    end else if (m_pos == 1) begin
      if (rom1[m_addr] == END_NOTE) begin
        m_n1 = '0; m_n2 = '0; m_addr = 0; m_pos = 0;
        if (!loop_en) begin m_mode = M_IDLE; m_done = 1'b1; end
      end else begin
        m_n1 = rom1[m_addr]; m_n2 = rom2[m_addr]; m_strobe = 1'b1; m_pos = 2;
      end
    end else if (m_pos == BEAT - 1) begin
      m_addr = (m_addr == MAX_ADDR) ? 0 : m_addr + 1;
      m_pos  = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_model();
    logic       snd;
    logic [6:0] e1, e2;
    snd = (m_mode == M_RUN) && (m_pos >= 2) && (m_pos < BEAT - GAP);
    e1  = snd ? m_n1 : 7'd0;
    e2  = snd ? m_n2 : 7'd0;
    chk("rom_addr",    32'(rom_addr),    32'(m_addr));
    chk("note1_out",   32'(note1_out),   32'(e1));
    chk("note2_out",   32'(note2_out),   32'(e2));
    chk("beat_strobe", 32'(beat_strobe), 32'(m_strobe));
    chk("done",        32'(done),        32'(m_done));
    chk("playing",     32'(playing),     32'(m_mode == M_RUN));
    chk("strobe_done_excl", 32'(beat_strobe & done), 32'd0);
    if (beat_strobe)
      $display("beat   t=%0t addr=%0d note1=%0d note2=%0d", $time, rom_addr, rom1[rom_addr], rom2[rom_addr]);
    if (done)
      $display("done   t=%0t", $time);
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
    check_model();
  endtask

  // Assert reset between clock edges and confirm outputs clear without a clock.
  task automatic async_reset();
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_addr",    32'(rom_addr),    32'd0);
    chk("arst_note1",   32'(note1_out),   32'd0);
    chk("arst_note2",   32'(note2_out),   32'd0);
    chk("arst_strobe",  32'(beat_strobe), 32'd0);
    chk("arst_done",    32'(done),        32'd0);
    chk("arst_playing", 32'(playing),     32'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic fill_rom_random(input int end_pct);
    for (int a = 0; a <= MAX_ADDR; a++) begin
      rom1[a] = ($urandom_range(0, 99) < end_pct) ? END_NOTE : 7'($urandom_range(0, 126));
      rom2[a] = 7'($urandom_range(0, 127));
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      rom1[a] = 7'd1;
      rom2[a] = 7'd2;
    end
    rom1[0] = 7'd10; rom2[0] = 7'd20;
    rom1[1] = 7'd30; rom2[1] = 7'd0;
    rom1[2] = END_NOTE; rom2[2] = 7'd5;
    model_reset();

    // Reset state.
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Basic beat timing, then end-of-tune with loop_en = 0.
    play = 1'b1;
    loop_en = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      tick();
      if (c == 2 || c == 10) chk("t1_strobe", 32'(beat_strobe), 32'd1);
      if (c >= 2 && c <= 5)  chk("t1_n1_hold", 32'(note1_out), 32'd10);
      if (c == 6 || c == 7)  chk("t1_n1_gap", 32'(note1_out), 32'd0);
      if (c == 8)            chk("t1_addr1", 32'(rom_addr), 32'd1);
      if (c == 10)           chk("t1_n1_beat1", 32'(note1_out), 32'd30);
      if (c == 18) begin
        chk("t2_done",    32'(done),      32'd1);
        chk("t2_playing", 32'(playing),   32'd0);
        chk("t2_addr",    32'(rom_addr),  32'd0);
        chk("t2_notes",   32'(note1_out), 32'd0);
      end
    end
    play = 1'b0;
    tick();

    // Looping: the marker word is skipped and address 0 follows without a gap.
    loop_en = 1'b1;
    play = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      tick();
      if (c >= 16)  chk("t3_playing", 32'(playing), 32'd1);
      if (c == 18)  chk("t3_addr0", 32'(rom_addr), 32'd0);
      if (c == 20) begin
        chk("t3_strobe", 32'(beat_strobe), 32'd1);
        chk("t3_n1",     32'(note1_out),   32'd10);
        chk("t3_n2",     32'(note2_out),   32'd20);
      end
    end

    // Pause at beat position 4 for 20 cycles, then finish the same beat.
    play = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t4_pause_n1",   32'(note1_out), 32'd0);
      chk("t4_pause_addr", 32'(rom_addr),  32'd0);
    end
    play = 1'b1;
    tick();
    chk("t4_resume_n1", 32'(note1_out), 32'd10);
    tick(); tick(); tick();
    chk("t4_addr_hold", 32'(rom_addr), 32'd0);
    tick();
    chk("t4_addr_adv", 32'(rom_addr), 32'd1);

    // Stop mid-SOUND at address 5, with play still high.
    stop = 1'b1;
    play = 1'b0;
    tick();
    stop = 1'b0;
    for (int a = 2; a <= MAX_ADDR; a++) begin
      rom1[a] = 7'($urandom_range(1, 126));
      rom2[a] = 7'($urandom_range(0, 127));
    end
    play = 1'b1;
    for (int k = 0; k < 200 && !(m_addr == 5 && m_pos == 3); k++) tick();
    chk("t5_reach_addr5", 32'(rom_addr), 32'd5);
    stop = 1'b1;
    tick();
    chk("t5_stop_playing", 32'(playing),   32'd0);
    chk("t5_stop_addr",    32'(rom_addr),  32'd0);
    chk("t5_stop_n1",      32'(note1_out), 32'd0);
    chk("t5_stop_done",    32'(done),      32'd0);
    stop = 1'b0;
    tick();
    chk("t5_replay", 32'(playing), 32'd1);

    // Address wrap after MAX_ADDR, then asynchronous reset mid-beat.
    for (int k = 0; k < 56; k++) tick();
    chk("t6_addr_max", 32'(rom_addr), 32'(MAX_ADDR));
    for (int k = 0; k < 8; k++) tick();
    chk("t6_addr_wrap", 32'(rom_addr), 32'd0);
    tick(); tick(); tick();
    async_reset();

    // Randomized controls over a random tune.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    fill_rom_random(15);
    play = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      stop = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) play = ~play;
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 999) == 0) async_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
